// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared opcodes, ALUOp codes and control bundle for the ID stage
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_NOP   = 6'b100000;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch;
    logic       branch_ne;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       alu_src;
    logic [2:0] alu_op;
  } ctrl_t;

  localparam int    CTRL_W = $bits(ctrl_t);
  localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/id_main_decoder.sv
// rtl/id_main_decoder.sv - combinational opcode-to-control table with illegal-opcode flag
module id_main_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]        opcode,
  output logic [CTRL_W-1:0] ctrl,
  output logic              uses_rt,
  output logic              illegal
);

  ctrl_t c;

  always_comb begin
    c       = BUBBLE;
    uses_rt = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        c.alu_op    = ALU_FUNCT;
        uses_rt     = 1'b1;
      end
      OP_LW: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.mem_read   = 1'b1;
        c.alu_src    = 1'b1;
        c.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_op    = ALU_ADD;
        uses_rt     = 1'b1;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
        c.alu_op = ALU_SUB;
        uses_rt  = 1'b1;
      end
      OP_BNE: begin
        c.branch    = 1'b1;
        c.branch_ne = 1'b1;
        c.alu_op    = ALU_SUB;
        uses_rt     = 1'b1;
      end
      OP_ADDI: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_op    = ALU_ADD;
      end
      OP_ANDI: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_op    = ALU_AND;
      end
      OP_ORI: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_op    = ALU_OR;
      end
      OP_NOP: c = BUBBLE;
      default: illegal = 1'b1;
    endcase
  end

  assign ctrl = c;

endmodule

// File: rtl/id_control_pipe.sv
// rtl/id_control_pipe.sv - ID-stage main control with load-use stall, branch flush and ID/EX register
module id_control_pipe
  import mips_ctrl_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int ALUOP_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        opcode_ID,
  input  logic [REG_AW-1:0] rs_ID,
  input  logic [REG_AW-1:0] rt_ID,
  input  logic              valid_ID,
  input  logic [REG_AW-1:0] rt_EX,
  input  logic              branch_taken,
  input  logic              illegal_clr,
  output logic              RegWrite_EX,
  output logic              MemtoReg_EX,
  output logic              Branch_EX,
  output logic              BranchNE_EX,
  output logic              MemRead_EX,
  output logic              MemWrite_EX,
  output logic              RegDst_EX,
  output logic              ALUSrc_EX,
  output logic [ALUOP_W-1:0] ALUOp_EX,
  output logic              valid_EX,
  output logic              stall_ID,
  output logic              flush_IFID,
  output logic              illegal_sticky
);

  localparam logic [2:0] CNT_RELOAD = 3'(FLUSH_CYCLES - 1);

  logic [CTRL_W-1:0] dec_bits;
  ctrl_t             dec;
  ctrl_t             ex;
  logic              uses_rt;
  logic              illegal;
  logic              valid_ex_q;
  logic [2:0]        cnt;
  logic              flush_active;
  logic              hazard;

  id_main_decoder u_dec (
    .opcode  (opcode_ID),
    .ctrl    (dec_bits),
    .uses_rt (uses_rt),
    .illegal (illegal)
  );

  assign dec = ctrl_t'(dec_bits);

  // A load in EX whose destination feeds this ID instruction needs one bubble.
  assign hazard = valid_ID & ex.mem_read & valid_ex_q & (rt_EX != '0) &
                  ((rt_EX == rs_ID) | (uses_rt & (rt_EX == rt_ID)));

  assign flush_active = branch_taken | (cnt != 3'd0);
  assign flush_IFID   = flush_active;
  assign stall_ID     = hazard & ~flush_active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt            <= 3'd0;
      ex             <= BUBBLE;
      valid_ex_q     <= 1'b0;
      illegal_sticky <= 1'b0;
    end else begin
      if (branch_taken)
        cnt <= CNT_RELOAD;
      else if (cnt != 3'd0)
        cnt <= cnt - 3'd1;

      // An unknown opcode is not a real instruction, so it enters EX as a bubble.
      if (flush_active | stall_ID | ~valid_ID | illegal) begin
        ex         <= BUBBLE;
        valid_ex_q <= 1'b0;
      end else begin
        ex         <= dec;
        valid_ex_q <= 1'b1;
      end

      if (illegal_clr)
        illegal_sticky <= 1'b0;
      else if (valid_ID & illegal)
        illegal_sticky <= 1'b1;
    end
  end

  assign RegWrite_EX = ex.reg_write;
  assign MemtoReg_EX = ex.mem_to_reg;
  assign Branch_EX   = ex.branch;
  assign BranchNE_EX = ex.branch_ne;
  assign MemRead_EX  = ex.mem_read;
  assign MemWrite_EX = ex.mem_write;
  assign RegDst_EX   = ex.reg_dst;
  assign ALUSrc_EX   = ex.alu_src;
  assign ALUOp_EX    = ALUOP_W'(ex.alu_op);
  assign valid_EX    = valid_ex_q;

endmodule

// File: tb/tb_id_control_pipe.sv
// tb/tb_id_control_pipe.sv - scoreboard bench for id_control_pipe (FLUSH_CYCLES 2, 1 and 7)
module tb_id_control_pipe;

  localparam logic [5:0] T_RTYPE = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011,
                         T_BEQ = 6'b000100, T_BNE = 6'b000101, T_ADDI = 6'b001000,
                         T_ANDI = 6'b001100, T_ORI = 6'b001101, T_NOP = 6'b100000,
                         T_BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic [4:0] rs = '0, rt = '0, rt_ex = '0;
  logic       valid_id = 1'b0, branch_taken = 1'b0, illegal_clr = 1'b0;

  logic [7:0] c0, c1, c7;
  logic [2:0] op0, op1, op7;
  logic       v0, v1, v7, s0, s1, s7, f0, f1, f7, i0, i1, i7;
  logic [11:0] obs;

  int checks = 0;
  int failures = 0;
  logic [11:0] sb[$];

  always #5 clk = ~clk;

  assign obs = {c0, op0, v0};

  id_control_pipe #(.REG_AW(5), .FLUSH_CYCLES(2), .ALUOP_W(3)) dut (
    .clk(clk), .rst(rst), .opcode_ID(opcode), .rs_ID(rs), .rt_ID(rt), .valid_ID(valid_id),
    .rt_EX(rt_ex), .branch_taken(branch_taken), .illegal_clr(illegal_clr),
    .RegWrite_EX(c0[7]), .MemtoReg_EX(c0[6]), .Branch_EX(c0[5]), .BranchNE_EX(c0[4]),
    .MemRead_EX(c0[3]), .MemWrite_EX(c0[2]), .RegDst_EX(c0[1]), .ALUSrc_EX(c0[0]),
    .ALUOp_EX(op0), .valid_EX(v0), .stall_ID(s0), .flush_IFID(f0), .illegal_sticky(i0));

  id_control_pipe #(.REG_AW(5), .FLUSH_CYCLES(1), .ALUOP_W(3)) dut1 (
    .clk(clk), .rst(rst), .opcode_ID(opcode), .rs_ID(rs), .rt_ID(rt), .valid_ID(valid_id),
    .rt_EX(rt_ex), .branch_taken(branch_taken), .illegal_clr(illegal_clr),
    .RegWrite_EX(c1[7]), .MemtoReg_EX(c1[6]), .Branch_EX(c1[5]), .BranchNE_EX(c1[4]),
    .MemRead_EX(c1[3]), .MemWrite_EX(c1[2]), .RegDst_EX(c1[1]), .ALUSrc_EX(c1[0]),
    .ALUOp_EX(op1), .valid_EX(v1), .stall_ID(s1), .flush_IFID(f1), .illegal_sticky(i1));

  id_control_pipe #(.REG_AW(5), .FLUSH_CYCLES(7), .ALUOP_W(3)) dut7 (
    .clk(clk), .rst(rst), .opcode_ID(opcode), .rs_ID(rs), .rt_ID(rt), .valid_ID(valid_id),
    .rt_EX(rt_ex), .branch_taken(branch_taken), .illegal_clr(illegal_clr),
    .RegWrite_EX(c7[7]), .MemtoReg_EX(c7[6]), .Branch_EX(c7[5]), .BranchNE_EX(c7[4]),
    .MemRead_EX(c7[3]), .MemWrite_EX(c7[2]), .RegDst_EX(c7[1]), .ALUSrc_EX(c7[0]),
    .ALUOp_EX(op7), .valid_EX(v7), .stall_ID(s7), .flush_IFID(f7), .illegal_sticky(i7));

  // {RegWrite,MemtoReg,Branch,BranchNE,MemRead,MemWrite,RegDst,ALUSrc,ALUOp}
  function automatic logic [10:0] exp_ctrl(input logic [5:0] op);
    case (op)
      T_RTYPE: return 11'b10000010_010;
      T_LW:    return 11'b11001001_000;
      T_SW:    return 11'b00000101_000;
      T_BEQ:   return 11'b00100000_001;
      T_BNE:   return 11'b00110000_001;
      T_ADDI:  return 11'b10000001_000;
      T_ANDI:  return 11'b10000001_011;
      T_ORI:   return 11'b10000001_100;
      default: return 11'b0;
    endcase
  endfunction

  task automatic drive(input logic [5:0] op, input logic [4:0] r_s, input logic [4:0] r_t,
                       input logic vid, input logic [4:0] r_ex, input logic bt, input logic clr);
    opcode = op; rs = r_s; rt = r_t; valid_id = vid; rt_ex = r_ex;
    branch_taken = bt; illegal_clr = clr;
  endtask

  task automatic test_reset();
    logic [11:0] e;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({obs, s0, f0, i0} !== 15'd0) begin
      failures++; $display("FAIL reset_hold got=%h exp=0", {obs, s0, f0, i0});
    end
    @(negedge clk); rst = 1'b0;
    drive(T_BAD, 0, 0, 1, 0, 0, 0);
    @(posedge clk); #1;
    checks++;
    if ({i0, v0} !== 2'b10) begin
      failures++; $display("FAIL reset_pre_illegal got=%b exp=10", {i0, v0});
    end
    @(negedge clk);
    drive(T_RTYPE, 0, 0, 1, 0, 0, 0);
    sb.push_back({exp_ctrl(T_RTYPE), 1'b1});
    @(posedge clk); #1;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL reset_pre_rtype got=%h exp=%h", obs, e); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({obs, s0, f0, i0} !== 15'd0) begin
      failures++; $display("FAIL reset_async got=%h exp=0", {obs, s0, f0, i0});
    end
    @(negedge clk); rst = 1'b0;
    drive(T_RTYPE, 0, 0, 1, 0, 0, 0);
    sb.push_back({exp_ctrl(T_RTYPE), 1'b1});
    @(posedge clk); #1;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL reset_first_edge got=%h exp=%h", obs, e); end
  endtask

  task automatic test_opcode_sweep();
    logic [5:0] ops[10] = '{T_RTYPE, T_LW, T_SW, T_BEQ, T_BNE, T_ADDI, T_ANDI, T_ORI, T_NOP, T_BAD};
    logic [11:0] e;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(ops[i], 0, 0, 1, 0, 0, 0);
      sb.push_back(ops[i] == T_BAD ? 12'd0 : {exp_ctrl(ops[i]), 1'b1});
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL sweep_op%0h got=%h exp=%h", ops[i], obs, e); end
    end
    checks++;
    if (i0 !== 1'b1) begin failures++; $display("FAIL sticky_set got=%b exp=1", i0); end
    @(negedge clk);
    drive(T_BAD, 0, 0, 1, 0, 0, 1);
    @(posedge clk); #1;
    checks++;
    if (i0 !== 1'b0) begin failures++; $display("FAIL sticky_clr_priority got=%b exp=0", i0); end
    @(negedge clk);
    drive(T_BAD, 0, 0, 0, 0, 0, 0);
    sb.push_back(12'd0);
    @(posedge clk); #1;
    e = sb.pop_front(); checks++;
    if ({obs, i0} !== {e, 1'b0}) begin
      failures++; $display("FAIL invalid_id got=%h exp=%h", {obs, i0}, {e, 1'b0});
    end
  endtask

  task automatic test_load_use();
    logic [5:0] ops[12] = '{T_LW, T_RTYPE, T_RTYPE, T_LW, T_RTYPE, T_LW, T_SW, T_SW, T_LW, T_ADDI, T_LW, T_BEQ};
    logic [4:0] rss[12] = '{0, 8, 8, 0, 0, 0, 1, 1, 0, 2, 0, 1};
    logic [4:0] rts[12] = '{8, 3, 3, 0, 0, 8, 8, 8, 8, 8, 8, 8};
    logic [4:0] rex[12] = '{0, 8, 8, 3, 0, 0, 8, 8, 8, 8, 8, 8};
    logic       stl[12] = '{0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    logic [11:0] e;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(ops[i], rss[i], rts[i], 1, rex[i], 0, 0);
      sb.push_back(stl[i] ? 12'd0 : {exp_ctrl(ops[i]), 1'b1});
      #1;
      checks++;
      if ({s0, f0} !== {stl[i], 1'b0}) begin
        failures++; $display("FAIL load_use_stall%0d got=%b exp=%b", i, {s0, f0}, {stl[i], 1'b0});
      end
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL load_use_ex%0d got=%h exp=%h", i, obs, e); end
    end
  endtask

  task automatic test_branch_flush();
    logic [11:0] e;
    int fc1 = 0, fc7 = 0, bc1 = 0, bc7 = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(T_RTYPE, 1, 2, 1, 0, (i == 0), 0);
      sb.push_back(i < 2 ? 12'd0 : {exp_ctrl(T_RTYPE), 1'b1});
      #1;
      checks++;
      if (f0 !== (i < 2)) begin failures++; $display("FAIL flush2_cyc%0d got=%b exp=%b", i, f0, (i < 2)); end
      fc1 += int'(f1); fc7 += int'(f7);
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL flush2_ex%0d got=%h exp=%h", i, obs, e); end
      bc1 += int'(!v1); bc7 += int'(!v7);
    end
    checks++;
    if ({fc1, bc1} !== {32'd1, 32'd1}) begin
      failures++; $display("FAIL flush1_count got=%0d/%0d exp=1/1", fc1, bc1);
    end
    checks++;
    if ({fc7, bc7} !== {32'd7, 32'd7}) begin
      failures++; $display("FAIL flush7_count got=%0d/%0d exp=7/7", fc7, bc7);
    end
  endtask

  task automatic test_simultaneous();
    logic [5:0] ops[8] = '{T_LW, T_RTYPE, T_RTYPE, T_RTYPE, T_RTYPE, T_RTYPE, T_RTYPE, T_RTYPE};
    logic [4:0] rss[8] = '{0, 8, 8, 8, 1, 1, 1, 1};
    logic [4:0] rex[8] = '{0, 8, 8, 0, 3, 3, 3, 3};
    logic       bts[8] = '{0, 1, 0, 0, 1, 1, 0, 0};
    logic       fls[8] = '{0, 1, 1, 0, 1, 1, 1, 0};
    logic [11:0] e;
    int bubbles = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(ops[i], rss[i], 3, 1, rex[i], bts[i], 0);
      sb.push_back(fls[i] ? 12'd0 : {exp_ctrl(ops[i]), 1'b1});
      #1;
      checks++;
      if ({s0, f0} !== {1'b0, fls[i]}) begin
        failures++; $display("FAIL simul_ctl%0d got=%b exp=%b", i, {s0, f0}, {1'b0, fls[i]});
      end
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL simul_ex%0d got=%h exp=%h", i, obs, e); end
      if (i >= 4) bubbles += int'(!v0);
    end
    checks++;
    if (bubbles != 3) begin failures++; $display("FAIL restart_bubbles got=%0d exp=3", bubbles); end
  endtask

  task automatic test_reset_flush();
    logic [11:0] e;
    @(negedge clk);
    drive(T_RTYPE, 1, 2, 1, 0, 1, 0);
    sb.push_back(12'd0);
    @(posedge clk); #1;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL rflush_bubble got=%h exp=%h", obs, e); end
    @(negedge clk);
    drive(T_RTYPE, 1, 2, 1, 0, 0, 0);
    #1;
    checks++;
    if (f0 !== 1'b1) begin failures++; $display("FAIL rflush_active got=%b exp=1", f0); end
    rst = 1'b1;
    #1;
    checks++;
    if ({f0, v0} !== 2'b00) begin failures++; $display("FAIL rflush_async got=%b exp=00", {f0, v0}); end
    #1 rst = 1'b0;
    sb.push_back({exp_ctrl(T_RTYPE), 1'b1});
    @(posedge clk); #1;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL rflush_first_edge got=%h exp=%h", obs, e); end
    @(negedge clk);
    drive(T_ORI, 1, 2, 1, 0, 0, 0);
    sb.push_back({exp_ctrl(T_ORI), 1'b1});
    #1;
    checks++;
    if (f0 !== 1'b0) begin failures++; $display("FAIL rflush_cleared got=%b exp=0", f0); end
    @(posedge clk); #1;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL rflush_next got=%h exp=%h", obs, e); end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_opcode_sweep();
    test_load_use();
    test_branch_flush();
    test_simultaneous();
    test_reset_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
